eth_udp_tx: RTL
===============

// Module: eth_udp_tx
// PURPOSE
//  Transmit-side frame builder between the command/readout logic and the Ethernet MAC TX AXI byte stream.
//  Latches reply header fields on start, computes the IPv4 header checksum and emits Eth+IPv4+UDP header (42 B).
//  Then serializes 32-bit payload words (txd/txvld/txend) MSB-first into bytes, with tlast on the final byte.
// PARAMETERS
//  TTL        8'd64   IPv4 time-to-live
//  MAXWORDS   368     max payload words (1472 B UDP payload, no IP fragmentation)
// PORTS
//  clk125      in   1   system clock, 125 MHz
//  reset       in   1   asynchronous, active-high reset
//  MAC         in   48  own MAC (Ethernet source)
//  IP          in   32  own IPv4 (IP source)
//  start       in   1   request frame; fields below sampled when start && start_ready
//  start_ready out  1   high in IDLE only
//  dst_mac     in   48  destination MAC
//  dst_ip      in   32  destination IPv4
//  src_port    in   16  UDP source port
//  dst_port    in   16  UDP destination port
//  nwords      in   9   payload length, 32-bit words
//  txd         in   32  payload word
//  txvld       in   1   txd valid
//  txend       in   1   marks last payload word (qualified by txvld)
//  txready     out  1   word accepted when txvld && txready
//  tdata       out  8   MAC TX byte
//  tvalid      out  1   byte valid
//  tready      in   1   MAC accepts byte
//  tlast       out  1   last byte of frame
//  tuser       out  1   frame bad (MAC drops it); valid with tlast
//  busy        out  1   not IDLE
//  err         out  1   one-cycle pulse on payload length mismatch or nwords > MAXWORDS
// BEHAVIOUR
//  Reset: all outputs 0 except start_ready=1; state IDLE; counters 0. Reset mid-frame aborts immediately (tvalid drops).
//  States: IDLE -> CSUM (10 cyc) -> FOLD (1 cyc) -> HDR (42 B) -> PAY (4*nwords B) -> IDLE; DRAIN as noted.
//  IDLE: start_ready=1; on start: latch fields; nwords>MAXWORDS -> err pulse, stay IDLE, no frame.
//  CSUM: 20-bit accumulator sums the 10 header 16-bit words (checksum word = 0), one per cycle.
//  FOLD: sum = acc[15:0]+acc[19:16], fold again, invert -> cksum. First tvalid = 12 cycles after start handshake.
//  HDR bytes: dst_mac, MAC, 08 00, 45 00, iplen=20+8+4*nwords, ident, 40 00, TTL, 11, cksum, IP, dst_ip,
//   src_port, dst_port, udplen=8+4*nwords, 00 00 (UDP checksum unused). Multi-byte fields MSB first.
//  Byte advances only on tvalid && tready; tdata/tvalid held stable while tready=0.
//  nwords=0: tlast on header byte 41, PAY skipped, txready never asserted.
//  PAY: one-word holding register; txready=1 when register empty (or emptied this cycle by byte 3 handshake).
//   Bytes txd[31:24],[23:16],[15:8],[7:0]; tvalid=0 while register empty (bubble allowed).
//  txend on word k<nwords-1: err pulse; words k+1..nwords-1 zero-filled without txready; tuser=1 with tlast.
//  Word nwords-1 without txend: tlast normally, tuser=0, err pulse, then DRAIN: txready=1, discard words until txend -> IDLE.
//  txvld outside PAY/DRAIN ignored (txready=0). start outside IDLE ignored.
//  Widths: iplen/udplen 16 bit, computed from 9-bit nwords with no overflow (<=1500).
// CONFIGURATION
//  ETH_UDP_TX_IPID_EN defined: 16-bit ident counter, reset 0, +1 per emitted frame (wraps FFFF->0000), used in header and checksum.
//  Undefined: ident constant 16'h0000.
// STRUCTURE
//  Package eth_pkg: ETH_TYPE_IP 16'h0800, ETH_TYPE_ARP 16'h0806, IP_TYPE_UDP 8'd17, IP_TYPE_ICMP 8'd1,
//   HDR_LEN 42, IP_HDR_LEN 20, UDP_HDR_LEN 8, state encoding.
//  Sub-module ip_checksum: sequential ones-complement accumulator (clear, add16, fold, result); reused by the ICMP reply path.
// TESTING
//  nwords=1, txd=32'h00000002 with txend, tready=1 -> 46 B frame, tlast on byte 45, iplen 0x0020, udplen 0x000C, cksum verified by model.
//  IP=10.0.0.2 -> 10.0.0.1, nwords=3 -> header cksum matches reference; random tready gaps -> identical byte sequence.
//  nwords=4, txend on word 1 -> words 2,3 zero-filled, tuser=1 with tlast, err one pulse.
//  nwords=2, txend on word 4 -> frame ends after word 1 with tuser=0, words 2-4 drained, err pulse, start_ready after txend.
//  nwords=0 -> 42 B frame, tlast on byte 41; nwords=369 -> err pulse, no tvalid.
//  reset asserted at byte 20 -> tvalid=0 same cycle, start_ready=1 after release; with ETH_UDP_TX_IPID_EN ident 0,1,2 on consecutive frames.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP constants, request struct and TX frame-builder state encoding.
package eth_pkg;
  localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
  localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
  localparam logic [7:0]  IP_TYPE_UDP  = 8'd17;
  localparam logic [7:0]  IP_TYPE_ICMP = 8'd1;
  localparam int HDR_LEN     = 42;
  localparam int IP_HDR_LEN  = 20;
  localparam int UDP_HDR_LEN = 8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CSUM, ST_FOLD, ST_HDR, ST_PAY, ST_DRAIN
  } tx_state_t;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [8:0]  nwords;
  } tx_req_t;
endpackage

// File: rtl/ip_checksum.sv
// Sequential ones-complement accumulator: clear, add one 16-bit word per cycle, fold+invert into result.
module ip_checksum (
  input  logic        clk125,
  input  logic        reset,
  input  logic        clear,
  input  logic        add,
  input  logic [15:0] din,
  input  logic        fold,
  output logic [15:0] result
);
  logic [19:0] acc;
  logic [16:0] s1;
  logic [15:0] s2;

  // two end-around folds cover any carry out of 20 bits of up to 16 words
  always_comb begin
    s1 = {1'b0, acc[15:0]} + {13'b0, acc[19:16]};
    s2 = s1[15:0] + {15'b0, s1[16]};
  end

  always_ff @(posedge clk125 or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (clear)    acc <= '0;
      else if (add) acc <= acc + {4'b0, din};
      if (fold) result <= ~s2;
    end
  end
endmodule

// File: rtl/eth_udp_tx.sv
// UDP/IPv4/Ethernet TX frame builder: 42-byte header then MSB-first payload bytes to the MAC.
// Define ETH_UDP_TX_IPID_EN for an incrementing IPv4 ident; otherwise ident is 0.
module eth_udp_tx import eth_pkg::*; #(
  parameter logic [7:0] TTL      = 8'd64,
  parameter int         MAXWORDS = 368
) (
  input  logic        clk125,
  input  logic        reset,
  input  logic [47:0] MAC,
  input  logic [31:0] IP,
  input  logic        start,
  output logic        start_ready,
  input  logic [47:0] dst_mac,
  input  logic [31:0] dst_ip,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic [8:0]  nwords,
  input  logic [31:0] txd,
  input  logic        txvld,
  input  logic        txend,
  output logic        txready,
  output logic [7:0]  tdata,
  output logic        tvalid,
  input  logic        tready,
  output logic        tlast,
  output logic        tuser,
  output logic        busy,
  output logic        err
);
  tx_state_t   state;
  tx_req_t     rq;
  logic [47:0] mac_q;
  logic [31:0] ip_q;
  logic [3:0]  cidx;
  logic [5:0]  hidx;
  logic [1:0]  bidx;
  logic [8:0]  wacc;
  logic [3:0][7:0] hold;
  logic        hfull, zfill, late;
  logic [15:0] ident, cksum, iplen, udplen, cw;
  logic        slot, fire_last, room, acc_w, zgen;
  logic [0:HDR_LEN-1][7:0] hb;

`ifdef ETH_UDP_TX_IPID_EN
  logic [15:0] ident_q;
  always_ff @(posedge clk125 or posedge reset) begin
    if (reset)          ident_q <= '0;
    else if (fire_last) ident_q <= ident_q + 16'd1;
  end
  assign ident = ident_q;
`else
  assign ident = 16'h0000;
`endif

  assign iplen  = 16'(IP_HDR_LEN + UDP_HDR_LEN) + {5'b0, rq.nwords, 2'b00};
  assign udplen = 16'(UDP_HDR_LEN) + {5'b0, rq.nwords, 2'b00};

  always_comb begin
    cw = '0;
    case (cidx)
      4'd0: cw = 16'h4500;
      4'd1: cw = iplen;
      4'd2: cw = ident;
      4'd3: cw = 16'h4000;
      4'd4: cw = {TTL, IP_TYPE_UDP};
      4'd6: cw = ip_q[31:16];
      4'd7: cw = ip_q[15:0];
      4'd8: cw = rq.dst_ip[31:16];
      4'd9: cw = rq.dst_ip[15:0];
      default: cw = '0;
    endcase
  end

  assign hb = {rq.dst_mac, mac_q, ETH_TYPE_IP, 16'h4500, iplen, ident, 16'h4000, TTL, IP_TYPE_UDP,
               cksum, ip_q, rq.dst_ip, rq.src_port, rq.dst_port, udplen, 16'h0000};

  ip_checksum u_csum (
    .clk125 (clk125),
    .reset  (reset),
    .clear  (state == ST_IDLE && start),
    .add    (state == ST_CSUM),
    .din    (cw),
    .fold   (state == ST_FOLD),
    .result (cksum)
  );

  // output slot frees when empty or the held byte is taken this cycle
  assign slot      = !tvalid || tready;
  assign fire_last = tvalid && tready && tlast;
  assign room      = (wacc < rq.nwords) && (!hfull || (slot && bidx == 2'd3));
  assign txready   = (state == ST_PAY && !zfill && room) || state == ST_DRAIN;
  assign acc_w     = state == ST_PAY && txvld && txready;
  assign zgen      = state == ST_PAY && zfill && room;
  assign start_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge clk125 or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      rq    <= '0;
      mac_q <= '0;
      ip_q  <= '0;
      cidx  <= '0;
      hidx  <= '0;
      bidx  <= '0;
      wacc  <= '0;
      hold  <= '0;
      hfull <= 1'b0;
      zfill <= 1'b0;
      late  <= 1'b0;
      tdata <= '0;
      tvalid <= 1'b0;
      tlast <= 1'b0;
      tuser <= 1'b0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          rq    <= {dst_mac, dst_ip, src_port, dst_port, nwords};
          mac_q <= MAC;
          ip_q  <= IP;
          cidx  <= '0;
          if (int'(nwords) > MAXWORDS) err <= 1'b1;
          else                         state <= ST_CSUM;
        end
        ST_CSUM: begin
          cidx <= cidx + 4'd1;
          if (cidx == 4'd9) state <= ST_FOLD;
        end
        ST_FOLD: begin
          tdata  <= hb[0];
          tvalid <= 1'b1;
          tlast  <= 1'b0;
          tuser  <= 1'b0;
          hidx   <= 6'd1;
          bidx   <= '0;
          wacc   <= '0;
          hfull  <= 1'b0;
          zfill  <= 1'b0;
          late   <= 1'b0;
          state  <= ST_HDR;
        end
        ST_HDR: begin
          if (fire_last) begin
            tvalid <= 1'b0;
            tlast  <= 1'b0;
            state  <= ST_IDLE;
          end else if (slot) begin
            tdata <= hb[hidx];
            tlast <= (hidx == 6'd41) && (rq.nwords == 9'd0);
            hidx  <= hidx + 6'd1;
            if (hidx == 6'd41 && rq.nwords != 9'd0) state <= ST_PAY;
          end
        end
        ST_PAY: begin
          if (fire_last) begin
            tvalid <= 1'b0;
            tlast  <= 1'b0;
            state  <= late ? ST_DRAIN : ST_IDLE;
          end else begin
            if (slot) begin
              if (hfull) begin
                tdata  <= hold[2'd3 - bidx];
                tvalid <= 1'b1;
                tlast  <= (bidx == 2'd3) && (wacc == rq.nwords);
                tuser  <= zfill;
                bidx   <= bidx + 2'd1;
                if (bidx == 2'd3) hfull <= 1'b0;
              end else begin
                tvalid <= 1'b0;
              end
            end
            if (acc_w || zgen) begin
              hold  <= zgen ? '0 : txd;
              hfull <= 1'b1;
              wacc  <= wacc + 9'd1;
            end
            // early txend pads with zeros and marks the frame bad; missing txend drains afterwards
            if (acc_w && txend && wacc != rq.nwords - 9'd1) begin
              zfill <= 1'b1;
              err   <= 1'b1;
            end
            if (acc_w && !txend && wacc == rq.nwords - 9'd1) begin
              late <= 1'b1;
              err  <= 1'b1;
            end
          end
        end
        ST_DRAIN: if (txvld && txend) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
